// File: rtl/app_pkg.sv
// Shared types and layout constants for the packet SRAM writer/reader pair.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package app_pkg;

  // Writer control states; the reader decodes the same packet layout.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COLLECT     = 2'd1,
    WRITE_COUNT = 2'd2,
    DONE        = 2'd3
  } wr_state_t;

  // Default SRAM address width (256-entry macro).
  localparam int unsigned APP_ADDR_WIDTH = $clog2(256);

  // Largest payload that fits: one word is reserved for the count.
  function automatic int unsigned max_bytes(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  localparam int unsigned MAX_BYTES = max_bytes(APP_ADDR_WIDTH);

  // Packet layout: byte count lives at address 0, payload starts at address 1.
  localparam int unsigned COUNT_ADDR   = 0;
  localparam int unsigned PAYLOAD_BASE = 1;

endpackage

// File: rtl/memory_writer.sv
// Streams one packet into a single-port SRAM as {count @0, payload @1..count}; optional MEMORY_WRITER_CHECKSUM_EN adds an XOR checksum output.
// Latency: byte accepted in cycle N -> data strobe N+1; last byte at N -> count strobe N+2, done from N+3.
// Backpressure: ready is high throughout COLLECT (overflow bytes are dropped, not stalled); ready low in IDLE/WRITE_COUNT/DONE.
module memory_writer
  import app_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(256)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  data_last,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] byte_count,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0
`ifdef MEMORY_WRITER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  // Payload capacity for this address width; the package constant covers the default build.
  localparam int unsigned MAX_B = (ADDR_WIDTH == APP_ADDR_WIDTH) ? MAX_BYTES : max_bytes(ADDR_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_COUNT = DATA_WIDTH'(MAX_B);
  localparam logic [ADDR_WIDTH-1:0] COUNT_A   = ADDR_WIDTH'(COUNT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PTR_INIT  = ADDR_WIDTH'(PAYLOAD_BASE);

  wr_state_t             state;
  wr_state_t             state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  accept;
  logic                  has_room;
  logic                  strobe_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] din_nxt;

  assign accept   = data_valid & ready;
  assign has_room = (byte_count != MAX_COUNT);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        if (start) state_nxt = COLLECT;
      COLLECT:     if (accept && data_last) state_nxt = WRITE_COUNT;
      WRITE_COUNT: state_nxt = DONE;
      // Leave DONE only once done has been seen high, so done is never skipped.
      DONE:        if (done && !start) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Output decode: ready plus the next SRAM strobe (registered below).
  always_comb begin
    ready      = 1'b0;
    strobe_nxt = 1'b0;
    addr_nxt   = addr0;
    din_nxt    = din0;
    unique case (state)
      COLLECT: begin
        ready = 1'b1;
        // Dropped overflow bytes produce no strobe.
        if (accept && has_room) begin
          strobe_nxt = 1'b1;
          addr_nxt   = ptr;
          din_nxt    = data_in;
        end
      end
      WRITE_COUNT: begin
        // byte_count already includes the final payload byte here.
        strobe_nxt = 1'b1;
        addr_nxt   = COUNT_A;
        din_nxt    = byte_count;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // SRAM port registers; a strobe lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else begin
      csb0  <= ~strobe_nxt;
      web0  <= ~strobe_nxt;
      addr0 <= addr_nxt;
      din0  <= din_nxt;
    end
  end

  // Packet bookkeeping: write pointer, saturating byte count, sticky overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr        <= PTR_INIT;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (state == IDLE && start) begin
      ptr        <= PTR_INIT;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      if (has_room) begin
        ptr        <= ptr + 1'b1;
        byte_count <= byte_count + 1'b1;
      end else begin
        overflow   <= 1'b1;
      end
    end
  end

  // done rises one cycle after entering DONE and drops as the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE) && (state_nxt == DONE);
    end
  end

`ifdef MEMORY_WRITER_CHECKSUM_EN
  // XOR of every byte actually written to the SRAM; frozen outside COLLECT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (accept && has_room) begin
      checksum <= checksum ^ data_in;
    end
  end
`endif

endmodule
